// File: rtl/stbuf_pkg.sv
// stbuf_pkg: store buffer widths, entry type, size codes and byte-lane mask helper
package stbuf_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int SIZE_WIDTH = 3;
  localparam int REG_DATA_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam logic [SIZE_WIDTH-1:0] SIZE_B = 3'd1;
  localparam logic [SIZE_WIDTH-1:0] SIZE_H = 3'd2;
  localparam logic [SIZE_WIDTH-1:0] SIZE_W = 3'd4;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [SIZE_WIDTH-1:0]     size;
    logic [REG_DATA_WIDTH-1:0] data;
  } stbuf_entry_t;
  function automatic logic [3:0] byte_mask(input logic [1:0] a, input logic [SIZE_WIDTH-1:0] s);
    return s == SIZE_B ? 4'b0001 << a : s == SIZE_H ? 4'b0011 << a : 4'b1111;
  endfunction
endpackage

// File: rtl/stbuf_forward.sv
// stbuf_forward: combinational store-to-load forwarding (entries/head/tail/load addr+size in; lane mask + lane data out)
module stbuf_forward
  import stbuf_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  stbuf_entry_t            entries_i [DEPTH],
  input  logic [PW-1:0]           head_i,
  input  logic [PW-1:0]           tail_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [SIZE_WIDTH-1:0]   size_i,
  output logic [3:0]              mask_o,
  output logic [REG_DATA_WIDTH-1:0] data_o
);
  always_comb begin
    logic [IW-1:0] idx;
    logic [3:0] m;
    logic [3:0] lm;
    logic [REG_DATA_WIDTH-1:0] sh;
    logic [PW-1:0] cnt;
    mask_o = '0;
    data_o = '0;
    idx = '0;
    m = '0;
    sh = '0;
    lm = byte_mask(addr_i[1:0], size_i);
    cnt = tail_i - head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i[IW-1:0] + IW'(i);
      m = byte_mask(entries_i[idx].addr[1:0], entries_i[idx].size) & lm;
      sh = entries_i[idx].data << {entries_i[idx].addr[1:0], 3'b000};
      if (PW'(i) < cnt && entries_i[idx].addr[ADDR_WIDTH-1:2] == addr_i[ADDR_WIDTH-1:2])
        for (int b = 0; b < 4; b++)
          if (m[b]) begin
            mask_o[b] = 1'b1;
            data_o[b*8+:8] = sh[b*8+:8];
          end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO with commit/flush and bus drain (LSU push/commit/flush in, bus write out), load pass-through with forwarded-byte merge (LSU read in, bus read out, merged data back)
module store_buffer
  import stbuf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_stbuf_push,
  input  logic [ADDR_WIDTH-1:0]     lsu_stbuf_addr,
  input  logic [SIZE_WIDTH-1:0]     lsu_stbuf_size,
  input  logic [REG_DATA_WIDTH-1:0] lsu_stbuf_data,
  output logic                      stbuf_lsu_push_ready,
  input  logic                      commit_stbuf_commit,
  input  logic                      commit_stbuf_flush,
  output logic                      stbuf_empty,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [REG_DATA_WIDTH-1:0] stbuf_bus_data,
  output logic                      stbuf_bus_wr,
  input  logic                      bus_stbuf_write_ready,
  input  logic [ADDR_WIDTH-1:0]     lsu_stbuf_read_addr,
  input  logic [SIZE_WIDTH-1:0]     lsu_stbuf_read_size,
  input  logic                      lsu_stbuf_rd,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  output logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
  output logic                      stbuf_bus_rd,
  input  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_read_data,
  output logic [REG_DATA_WIDTH-1:0] stbuf_lsu_read_data,
  output logic                      stbuf_lsu_read_valid
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  stbuf_entry_t mem_q [DEPTH];
  stbuf_entry_t head_e;
  logic [PW-1:0] head_q, cmt_q, tail_q, head_d, cmt_d, tail_d, count;
  logic push_ok, commit_ok, drain;
  logic rd_v_q;
  logic [1:0] rd_off_q;
  logic [SIZE_WIDTH-1:0] rd_size_q;
  logic [3:0] fwd_mask, fwd_mask_q;
  logic [REG_DATA_WIDTH-1:0] fwd_data, fwd_data_q, lanes, merged, shifted;
  assign stbuf_bus_read_addr = lsu_stbuf_read_addr;
  assign stbuf_bus_read_size = lsu_stbuf_read_size;
  assign stbuf_bus_rd = lsu_stbuf_rd;
  assign stbuf_lsu_read_valid = rd_v_q;
  stbuf_forward #(.DEPTH(DEPTH)) u_fwd (
    .entries_i(mem_q),
    .head_i(head_q),
    .tail_i(tail_q),
    .addr_i(lsu_stbuf_read_addr),
    .size_i(lsu_stbuf_read_size),
    .mask_o(fwd_mask),
    .data_o(fwd_data)
  );
  always_comb begin
    count = tail_q - head_q;
    stbuf_lsu_push_ready = count != PW'(DEPTH);
    stbuf_empty = count == '0;
    push_ok = lsu_stbuf_push && stbuf_lsu_push_ready;
    commit_ok = commit_stbuf_commit && cmt_q != tail_q;
    stbuf_bus_wr = head_q != cmt_q;
    head_e = mem_q[head_q[IW-1:0]];
    stbuf_bus_write_addr = stbuf_bus_wr ? head_e.addr : '0;
    stbuf_bus_write_size = stbuf_bus_wr ? head_e.size : '0;
    stbuf_bus_data = stbuf_bus_wr ? head_e.data : '0;
    drain = stbuf_bus_wr && bus_stbuf_write_ready;
    // commit lands before flush so a same-cycle commit survives the flush
    cmt_d = cmt_q + PW'(commit_ok);
    tail_d = commit_stbuf_flush ? cmt_d : tail_q + PW'(push_ok);
    head_d = head_q + PW'(drain);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q <= '0;
      tail_q <= '0;
      rd_v_q <= 1'b0;
      rd_off_q <= '0;
      rd_size_q <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q <= cmt_d;
      tail_q <= tail_d;
      rd_v_q <= lsu_stbuf_rd;
      rd_off_q <= lsu_stbuf_read_addr[1:0];
      rd_size_q <= lsu_stbuf_read_size;
      fwd_mask_q <= fwd_mask;
      fwd_data_q <= fwd_data;
    end
  end
  always_ff @(posedge clk)
    if (!rst && push_ok && !commit_stbuf_flush)
      mem_q[tail_q[IW-1:0]] <= '{lsu_stbuf_addr, lsu_stbuf_size, lsu_stbuf_data};
  always_ff @(posedge clk)
    if (!rst) assert (!(commit_stbuf_commit && cmt_q == tail_q));
  always_comb begin
    lanes = bus_stbuf_read_data << {rd_off_q, 3'b000};
    merged = lanes;
    for (int b = 0; b < 4; b++)
      merged[b*8+:8] = fwd_mask_q[b] ? fwd_data_q[b*8+:8] : lanes[b*8+:8];
    shifted = merged >> {rd_off_q, 3'b000};
    stbuf_lsu_read_data = !rd_v_q ? '0 :
                          rd_size_q == SIZE_B ? {24'b0, shifted[7:0]} :
                          rd_size_q == SIZE_H ? {16'b0, shifted[15:0]} : shifted;
  end
endmodule
